// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART frame controller:
// state encoding, error codes, header bytes and baud table.
package uart_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h55;

  // Cycles per bit for a baud selector, truncated.
  function automatic logic [15:0] baud_bits(
    input logic [1:0]  sel,
    input int unsigned clk_hz
  );
    int unsigned rate;
    case (sel)
      2'd0:    rate = 9600;
      2'd1:    rate = 57600;
      2'd2:    rate = 115200;
      default: rate = 921600;
    endcase
    return 16'(clk_hz / rate);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: clears on a byte, counts while
// enabled, pulses tmo on the edge it reaches LIMIT.
module uart_gap_timer #(
  parameter int unsigned LIMIT = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tmo
);

  localparam logic [23:0] LIM = 24'(LIMIT);

  logic [23:0] cnt;

  // Saturating up-counter, held at zero when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 24'd1;
    end
  end

  // A byte in the same cycle wins over the timeout.
  assign tmo = en & ~clr & (cnt == LIM - 24'd1);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame-level UART controller: baud setup, header sync,
// pixel payload write-out, checksum and frame hand-off.
module uart_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned IMG_BYTES   = 784,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        baud_sel,
  output logic [15:0]       bit_clk,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(IMG_BYTES - 1);
  localparam logic [15:0] BIT_RST =
    baud_bits(2'd2, CLK_FREQ);

  logic [2:0]        state;
  logic              rx_prev;
  logic [ADDR_W-1:0] count;
  logic [7:0]        csum;
  logic              byte_ev;
  logic              gap_en;
  logic              tmo;

  assign byte_ev = rx_done & ~rx_prev;
  assign gap_en  = (state == ST_SYNC)
                 | (state == ST_PAYLOAD)
                 | (state == ST_CSUM);
  assign busy        = gap_en;
  assign frame_valid = (state == ST_HOLD);

  uart_gap_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_gap (
    .clk (clk),
    .rst (rst),
    .clr (byte_ev),
    .en  (gap_en),
    .tmo (tmo)
  );

  // Frame FSM with pixel write-out, checksum and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rx_prev  <= 1'b0;
      count    <= '0;
      csum     <= '0;
      bit_clk  <= BIT_RST;
      pix_we   <= 1'b0;
      pix_addr <= '0;
      pix_data <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      rx_prev <= rx_done;
      pix_we  <= 1'b0;
      err     <= 1'b0;
      if (state == ST_IDLE) begin
        bit_clk <= baud_bits(baud_sel, CLK_FREQ);
      end
      if (tmo) begin
        state    <= ST_IDLE;
        err      <= 1'b1;
        err_code <= ERR_TMO;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_ev && rx_data == HDR0) begin
              state <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (byte_ev) begin
              if (rx_data == HDR1) begin
                state <= ST_PAYLOAD;
                count <= '0;
                csum  <= '0;
              end else if (rx_data != HDR0) begin
                state <= ST_IDLE;
              end
            end
          end
          ST_PAYLOAD: begin
            if (byte_ev) begin
              pix_we   <= 1'b1;
              pix_addr <= count;
              pix_data <= rx_data;
              csum     <= csum + rx_data;
              if (count == LAST) begin
                state <= ST_CSUM;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          ST_CSUM: begin
            if (byte_ev) begin
              if (rx_data == csum) begin
                state <= ST_HOLD;
              end else begin
                state    <= ST_IDLE;
                err      <= 1'b1;
                err_code <= ERR_CSUM;
              end
            end
          end
          ST_HOLD: begin
            if (frame_ack) begin
              if (byte_ev && rx_data == HDR0) begin
                state <= ST_SYNC;
              end else begin
                state <= ST_IDLE;
              end
            end else if (byte_ev) begin
              err      <= 1'b1;
              err_code <= ERR_OVR;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: vector tables,
// hand-written corner sequences and randomized frames.
module tb_uart_frame_ctrl;

  localparam int IMG = 784;
  localparam int AW  = 10;
  localparam int TMO = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    baud_sel;
  logic [15:0]   bit_clk;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_data;
  logic          frame_valid;
  logic          frame_ack;
  logic          err;
  logic [1:0]    err_code;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int err_pulses = 0;
  int we_pulses = 0;
  int last_we_cyc = 0;
  int last_err_cyc = 0;

  logic [17:0] exp_q[$];
  logic [7:0]  pay[IMG];

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] bits;
  } baud_vec_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       busy;
  } seq_vec_t;

  baud_vec_t bv[4];
  seq_vec_t  sv[5];

  uart_frame_ctrl #(
    .CLK_FREQ    (50000000),
    .IMG_BYTES   (IMG),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_sel    (baud_sel),
    .bit_clk     (bit_clk),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .err         (err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Scoreboard for pixel writes and error pulse log.
  always @(negedge clk) begin : mon
    logic [17:0] e;
    if (!rst) begin
      if (pix_we) begin
        we_pulses++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("pix_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_addr", 32'(pix_addr), 32'(e[17:8]));
          chk("pix_data", 32'(pix_data), 32'(e[7:0]));
        end
      end
      if (err) begin
        err_pulses++;
        last_err_cyc = cyc;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b,
                           input int hold,
                           input int gap);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rnd_byte(input logic [7:0] b);
    send_byte(b, $urandom_range(1, 3),
              $urandom_range(1, 3));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] pay_sum();
    int s = 0;
    for (int i = 0; i < IMG; i++) s += int'(pay[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_body(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({10'(i), pay[i]});
      if (rnd) rnd_byte(pay[i]);
      else send_byte(pay[i], 1, 1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bit_clk"}, 32'(bit_clk), 32'd434);
    chk({tag, "_pix_we"}, 32'(pix_we), 32'd0);
    chk({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    chk({tag, "_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e0;
    int w0;
    int kind;
    logic [7:0] cs;
    logic [7:0] jb;

    bv[0] = '{2'd3, 16'd54};
    bv[1] = '{2'd0, 16'd5208};
    bv[2] = '{2'd1, 16'd868};
    bv[3] = '{2'd2, 16'd434};

    sv[0] = '{8'hAA, 8'h13, 1'b0};
    sv[1] = '{8'hAA, 8'hAA, 1'b1};
    sv[2] = '{8'hAA, 8'h55, 1'b1};
    sv[3] = '{8'h13, 8'hAA, 1'b1};
    sv[4] = '{8'h55, 8'h13, 1'b0};

    baud_sel = 2'd2;
    do_reset();
    chk_reset_vals("rst");

    for (int i = 0; i < 4; i++) begin
      baud_sel = bv[i].sel;
      @(negedge clk);
      chk("baud_tab", 32'(bit_clk), 32'(bv[i].bits));
    end

    for (int i = 0; i < 5; i++) begin
      e0 = err_pulses;
      send_byte(sv[i].b0, 1, 1);
      send_byte(sv[i].b1, 1, 1);
      chk("seq_busy", 32'(busy), 32'(sv[i].busy));
      chk("seq_err", 32'(err_pulses - e0), 32'd0);
      do_reset();
    end

    // Good frame, baud change mid-frame, overrun, ack+AA.
    baud_sel = 2'd3;
    @(negedge clk);
    chk("baud_idle", 32'(bit_clk), 32'd54);
    for (int i = 0; i < IMG; i++) pay[i] = 8'(i % 256);
    w0 = we_pulses;
    e0 = err_pulses;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h55, 1, 1);
    baud_sel = 2'd0;
    send_body(IMG, 1'b0);
    send_byte(pay_sum(), 1, 1);
    chk("good_bit_clk_hold", 32'(bit_clk), 32'd54);
    chk("good_valid", 32'(frame_valid), 32'd1);
    chk("good_busy", 32'(busy), 32'd0);
    chk("good_writes", 32'(we_pulses - w0), 32'(IMG));
    chk("good_q_empty", 32'(exp_q.size()), 32'd0);
    chk("good_err", 32'(err_pulses - e0), 32'd0);
    send_byte(8'h11, 1, 1);
    send_byte(8'h22, 2, 1);
    chk("ovr_count", 32'(err_pulses - e0), 32'd2);
    chk("ovr_code", 32'(err_code), 32'd3);
    chk("ovr_valid", 32'(frame_valid), 32'd1);
    e0 = err_pulses;
    frame_ack = 1'b1;
    rx_data   = 8'hAA;
    rx_done   = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_done   = 1'b0;
    chk("ackaa_valid", 32'(frame_valid), 32'd0);
    chk("ackaa_busy", 32'(busy), 32'd1);
    chk("ackaa_err", 32'(err_pulses - e0), 32'd0);
    chk("sync_bit_clk", 32'(bit_clk), 32'd54);
    @(negedge clk);
    send_byte(8'h13, 1, 1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_bit_clk", 32'(bit_clk), 32'd5208);

    // Checksum byte of 0x00 on the same payload.
    baud_sel = 2'd2;
    e0 = err_pulses;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h55, 1, 1);
    send_body(IMG, 1'b0);
    send_byte(8'h00, 1, 1);
    chk("bad_err", 32'(err_pulses - e0), 32'd1);
    chk("bad_code", 32'(err_code), 32'd1);
    chk("bad_valid", 32'(frame_valid), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);

    // Timeout after 100 payload bytes.
    e0 = err_pulses;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h55, 1, 1);
    for (int i = 0; i < IMG; i++) pay[i] = 8'($urandom);
    send_body(100, 1'b1);
    for (int i = 0; i < TMO + 20; i++) begin
      if (err_pulses != e0) break;
      @(negedge clk);
    end
    chk("tmo_seen", 32'(err_pulses - e0), 32'd1);
    chk("tmo_delay", 32'(last_err_cyc - last_we_cyc),
        32'(TMO));
    chk("tmo_code", 32'(err_code), 32'd2);
    chk("tmo_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("tmo_once", 32'(err_pulses - e0), 32'd1);

    // Reset in the middle of a payload.
    send_byte(8'hAA, 1, 1);
    send_byte(8'h55, 1, 1);
    send_body(5, 1'b0);
    rx_data = 8'h77;
    rx_done = 1'b1;
    rst     = 1'b1;
    #1;
    chk_reset_vals("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_we", 32'(pix_we), 32'd0);
    end
    rx_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_q", 32'(exp_q.size()), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Randomized frames checked against scenario rules.
    for (int k = 0; k < 6; k++) begin
      kind = k % 4;
      e0 = err_pulses;
      w0 = we_pulses;
      if (kind == 2) begin
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
          jb = 8'($urandom);
          if (jb == 8'hAA) jb = 8'h13;
          rnd_byte(jb);
        end
      end
      rnd_byte(8'hAA);
      if (kind == 3) rnd_byte(8'hAA);
      rnd_byte(8'h55);
      for (int i = 0; i < IMG; i++) pay[i] = 8'($urandom);
      cs = pay_sum();
      if (kind == 1) cs = cs + 8'($urandom_range(1, 255));
      send_body(IMG, 1'b1);
      rnd_byte(cs);
      chk("rnd_writes", 32'(we_pulses - w0), 32'(IMG));
      chk("rnd_q_empty", 32'(exp_q.size()), 32'd0);
      if (kind == 1) begin
        chk("rnd_bad_err", 32'(err_pulses - e0), 32'd1);
        chk("rnd_bad_code", 32'(err_code), 32'd1);
        chk("rnd_bad_valid", 32'(frame_valid), 32'd0);
      end else begin
        chk("rnd_ok_err", 32'(err_pulses - e0), 32'd0);
        chk("rnd_ok_valid", 32'(frame_valid), 32'd1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("rnd_ack_valid", 32'(frame_valid), 32'd0);
        chk("rnd_ack_busy", 32'(busy), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
